writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
Writeback stage directly downstream of the ALU/misc, memory and mul/div functional units. It captures each unit's registered result (oper, regdest, writereg, wbvalue) into a small per-unit queue and arbitrates the single ARF write port. It reports each completion to issue and asserts back-pressure before any queue can overflow.

Parameters:
DEPTH, 2, entries per unit queue (power of two, >= 2)
CNTW, 2, width of per-queue occupancy counter (log2(DEPTH)+1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low
am_wb_oper  input  1  ALU/misc result valid this cycle
am_wb_regdest  input  5  ALU/misc destination register
am_wb_writereg  input  1  ALU/misc write request (overflow already folded in)
am_wb_wbvalue  input  32  ALU/misc result
mem_wb_oper / mem_wb_regdest / mem_wb_writereg / mem_wb_wbvalue  input  1/5/1/32  memory unit result, same meaning
md_wb_oper / md_wb_regdest / md_wb_writereg / md_wb_wbvalue  input  1/5/1/32  mul/div unit result, same meaning
wb_rf_writeenable  output  1  ARF write strobe
wb_rf_writeaddr  output  5  ARF write address
wb_rf_writedata  output  32  ARF write data
wb_iss_done  output  1  one instruction retired this cycle
wb_iss_doneunit  output  2  retiring unit: 0=am, 1=mem, 2=md
wb_iss_doneregdest  output  5  retiring instruction's regdest (scoreboard clear)
wb_iss_stall  output  1  issue must not dispatch
wb_overflow  output  1  sticky error: push into a full queue

Behaviour:
- Reset: asynchronous, active-low. All queues empty, all counters 0. All outputs 0. Reset mid-operation discards queued entries.
- Enqueue: at each posedge, each unit whose *_oper=1 pushes {regdest, writereg, wbvalue} into its own queue. Up to three pushes per cycle. *_oper=0 pushes nothing, whatever the other inputs are.
- Entries with writereg=0 are still queued. They retire with wb_iss_done=1 and wb_rf_writeenable=0.
- Arbitration: each posedge selects at most one head among the non-empty queues, by fixed priority mem > md > am. That entry is popped and loaded into the output registers.
- Latency: an entry pushed at edge N is eligible at edge N+1. With no competition, outputs reflect it during cycle N+1 to N+2, so latency is 2 cycles from *_oper.
- Outputs after each edge:
  - Entry popped: wb_iss_done=1, doneunit and doneregdest from the entry, wb_rf_writeaddr=regdest, wb_rf_writedata=wbvalue.
  - wb_rf_writeenable = writereg AND (regdest != 0). Writes to $0 are always suppressed.
  - No pop: wb_iss_done=0, wb_rf_writeenable=0, addr/data/doneunit/doneregdest hold their previous values.
- Simultaneous push and pop on the same queue in one edge: count unchanged, FIFO order kept. The head popped is the pre-edge head.
- Queue pointers are log2(DEPTH)-bit and wrap modulo DEPTH. Count is 0..DEPTH.
- Full: a push into a queue with count==DEPTH and no same-edge pop drops the new entry and sets wb_overflow=1. wb_overflow stays 1 until reset. Queue contents are unchanged.
- wb_iss_stall: combinational, 1 when any queue count >= DEPTH-1. This gives one cycle of slack for a result already in flight.
- Order: per unit, retirement follows arrival order. Across units, there is no ordering guarantee beyond the priority rule.

Test Plan:
- Reset then single am push (regdest=5, writereg=1, value=0x1234_5678) at edge 1 -> edge 2: we=1, addr=5, data=0x12345678, done=1, doneunit=0. Edge 3: we=0, done=0.
- Same edge pushes: am(r3, 0xA), mem(r4, 0xB), md(r6, 0xC) -> retire mem, then md, then am on three consecutive edges. wb_iss_done high for all three cycles.
- am push regdest=0, writereg=1 -> done=1, doneregdest=0, we=0. am push r7 with writereg=0 -> done=1, we=0.
- Hold mem pushing every cycle while 3 am entries arrive -> am queue reaches DEPTH, stall=1 from count 1. A 3rd am push while full sets overflow=1 and the dropped value never appears on wb_rf_writedata. am drains in order once mem stops.
- 6+ alternating push/pop cycles on one queue -> pointer wrap, values retire in FIFO order, count never exceeds DEPTH.
- Assert reset low with 2 entries queued and overflow=1 -> all outputs 0 immediately (asynchronous). After release, the old entries never retire.

Source files
------------

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter
// Description : Writeback stage. Queues ALU/misc, memory and mul/div results
//               in per-unit FIFOs and arbitrates the single ARF write port
//               (fixed priority mem > md > am). Reports retirement to issue
//               and raises stall before any queue can overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_arbiter #(
    parameter int DEPTH = 2,
    parameter int CNTW  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        am_wb_oper,
    input  logic [4:0]  am_wb_regdest,
    input  logic        am_wb_writereg,
    input  logic [31:0] am_wb_wbvalue,
    input  logic        mem_wb_oper,
    input  logic [4:0]  mem_wb_regdest,
    input  logic        mem_wb_writereg,
    input  logic [31:0] mem_wb_wbvalue,
    input  logic        md_wb_oper,
    input  logic [4:0]  md_wb_regdest,
    input  logic        md_wb_writereg,
    input  logic [31:0] md_wb_wbvalue,
    output logic        wb_rf_writeenable,
    output logic [4:0]  wb_rf_writeaddr,
    output logic [31:0] wb_rf_writedata,
    output logic        wb_iss_done,
    output logic [1:0]  wb_iss_doneunit,
    output logic [4:0]  wb_iss_doneregdest,
    output logic        wb_iss_stall,
    output logic        wb_overflow
);

    // Queue entry layout: {regdest[37:33], writereg[32], wbvalue[31:0]}
    localparam int              c_PW   = $clog2(DEPTH);
    localparam int              c_EW   = 38;
    localparam logic [CNTW-1:0] c_FULL = CNTW'(DEPTH);
    localparam logic [CNTW-1:0] c_HIGH = CNTW'(DEPTH - 1);

    // Unit index: 0 = am, 1 = mem, 2 = md (matches wb_iss_doneunit encoding)
    logic [2:0]      w_oper;
    logic [c_EW-1:0] w_entry [3];
    logic [c_EW-1:0] w_head  [3];
    logic [2:0]      w_nonempty;
    logic [2:0]      w_full;
    logic [2:0]      w_hiwater;
    logic [2:0]      w_pop;
    logic [2:0]      w_drop;
    logic [1:0]      w_sel_unit;
    logic [c_EW-1:0] w_sel_entry;

    logic            r_we;
    logic [4:0]      r_addr;
    logic [31:0]     r_data;
    logic            r_done;
    logic [1:0]      r_doneunit;
    logic [4:0]      r_doneregdest;
    logic            r_overflow;

    assign w_oper     = {md_wb_oper, mem_wb_oper, am_wb_oper};
    assign w_entry[0] = {am_wb_regdest,  am_wb_writereg,  am_wb_wbvalue};
    assign w_entry[1] = {mem_wb_regdest, mem_wb_writereg, mem_wb_wbvalue};
    assign w_entry[2] = {md_wb_regdest,  md_wb_writereg,  md_wb_wbvalue};

    // A push into a full queue is only lost when that queue is not also popped
    assign w_drop = w_oper & w_full & ~w_pop;

    genvar u;
    generate
        for (u = 0; u < 3; u++) begin : g_queue
            logic [c_EW-1:0] r_mem [DEPTH];
            logic [c_PW-1:0] r_wptr;
            logic [c_PW-1:0] r_rptr;
            logic [CNTW-1:0] r_count;
            logic            w_push;

            assign w_full[u]     = (r_count == c_FULL);
            assign w_nonempty[u] = (r_count != '0);
            assign w_hiwater[u]  = (r_count >= c_HIGH);
            assign w_head[u]     = r_mem[r_rptr];
            assign w_push        = w_oper[u] & (~w_full[u] | w_pop[u]);

            // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                end else begin
                    if (w_push)   r_wptr <= r_wptr + 1'b1;
                    if (w_pop[u]) r_rptr <= r_rptr + 1'b1;
                    case ({w_push, w_pop[u]})
                        2'b10:   r_count <= r_count + 1'b1;
                        2'b01:   r_count <= r_count - 1'b1;
                        default: r_count <= r_count;
                    endcase
                end
            end

            // Storage needs no reset: validity is tracked by the counter
            always_ff @(posedge clock) begin
                if (w_push) r_mem[r_wptr] <= w_entry[u];
            end
        end
    endgenerate

    // Fixed-priority head selection: mem first, then md, then am
    always_comb begin
        w_pop       = 3'b000;
        w_sel_unit  = 2'd0;
        w_sel_entry = w_head[0];
        if (w_nonempty[1]) begin
            w_pop[1]    = 1'b1;
            w_sel_unit  = 2'd1;
            w_sel_entry = w_head[1];
        end else if (w_nonempty[2]) begin
            w_pop[2]    = 1'b1;
            w_sel_unit  = 2'd2;
            w_sel_entry = w_head[2];
        end else if (w_nonempty[0]) begin
            w_pop[0]    = 1'b1;
            w_sel_unit  = 2'd0;
            w_sel_entry = w_head[0];
        end
    end

    // Retirement/output registers; address and data hold when nothing retires
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
            r_done        <= 1'b0;
            r_doneunit    <= '0;
            r_doneregdest <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_overflow <= r_overflow | (|w_drop);
            if (|w_pop) begin
                r_done        <= 1'b1;
                r_we          <= w_sel_entry[32] & (w_sel_entry[37:33] != 5'd0);
                r_addr        <= w_sel_entry[37:33];
                r_data        <= w_sel_entry[31:0];
                r_doneunit    <= w_sel_unit;
                r_doneregdest <= w_sel_entry[37:33];
            end else begin
                r_done <= 1'b0;
                r_we   <= 1'b0;
            end
        end
    end

    assign wb_rf_writeenable  = r_we;
    assign wb_rf_writeaddr    = r_addr;
    assign wb_rf_writedata    = r_data;
    assign wb_iss_done        = r_done;
    assign wb_iss_doneunit    = r_doneunit;
    assign wb_iss_doneregdest = r_doneregdest;
    assign wb_iss_stall       = |w_hiwater;
    assign wb_overflow        = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_arbiter
// Description : Directed, table-driven bench for writeback_arbiter (DEPTH=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_arbiter;

    logic        clock;
    logic        reset;
    logic        am_wb_oper,  mem_wb_oper,  md_wb_oper;
    logic [4:0]  am_wb_regdest, mem_wb_regdest, md_wb_regdest;
    logic        am_wb_writereg, mem_wb_writereg, md_wb_writereg;
    logic [31:0] am_wb_wbvalue, mem_wb_wbvalue, md_wb_wbvalue;
    logic        wb_rf_writeenable;
    logic [4:0]  wb_rf_writeaddr;
    logic [31:0] wb_rf_writedata;
    logic        wb_iss_done;
    logic [1:0]  wb_iss_doneunit;
    logic [4:0]  wb_iss_doneregdest;
    logic        wb_iss_stall;
    logic        wb_overflow;

    int checks   = 0;
    int failures = 0;

    writeback_arbiter #(.DEPTH(2), .CNTW(2)) dut (
        .clock              (clock),
        .reset              (reset),
        .am_wb_oper         (am_wb_oper),
        .am_wb_regdest      (am_wb_regdest),
        .am_wb_writereg     (am_wb_writereg),
        .am_wb_wbvalue      (am_wb_wbvalue),
        .mem_wb_oper        (mem_wb_oper),
        .mem_wb_regdest     (mem_wb_regdest),
        .mem_wb_writereg    (mem_wb_writereg),
        .mem_wb_wbvalue     (mem_wb_wbvalue),
        .md_wb_oper         (md_wb_oper),
        .md_wb_regdest      (md_wb_regdest),
        .md_wb_writereg     (md_wb_writereg),
        .md_wb_wbvalue      (md_wb_wbvalue),
        .wb_rf_writeenable  (wb_rf_writeenable),
        .wb_rf_writeaddr    (wb_rf_writeaddr),
        .wb_rf_writedata    (wb_rf_writedata),
        .wb_iss_done        (wb_iss_done),
        .wb_iss_doneunit    (wb_iss_doneunit),
        .wb_iss_doneregdest (wb_iss_doneregdest),
        .wb_iss_stall       (wb_iss_stall),
        .wb_overflow        (wb_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Unit stimulus packed as {oper, regdest, writereg, wbvalue}
    typedef struct {
        logic [38:0] am;
        logic [38:0] mem;
        logic [38:0] md;
        logic        e_done;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [1:0]  e_unit;
        logic [4:0]  e_rd;
        logic        e_stall;
        logic        e_ovf;
    } vec_t;

    localparam logic [38:0] c_NONE = 39'h0;

    vec_t vecs[$];

    function automatic logic [38:0] pu(input logic [4:0] rd, input logic wr, input logic [31:0] v);
        return {1'b1, rd, wr, v};
    endfunction

    function automatic vec_t mk(input logic [38:0] am, input logic [38:0] mem, input logic [38:0] md,
                                input logic done, input logic we, input logic [4:0] addr,
                                input logic [31:0] data, input logic [1:0] unit, input logic [4:0] rd,
                                input logic stall, input logic ovf);
        vec_t v;
        v.am = am; v.mem = mem; v.md = md;
        v.e_done = done; v.e_we = we; v.e_addr = addr; v.e_data = data;
        v.e_unit = unit; v.e_rd = rd; v.e_stall = stall; v.e_ovf = ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [38:0] am, input logic [38:0] mem, input logic [38:0] md);
        {am_wb_oper,  am_wb_regdest,  am_wb_writereg,  am_wb_wbvalue}  = am;
        {mem_wb_oper, mem_wb_regdest, mem_wb_writereg, mem_wb_wbvalue} = mem;
        {md_wb_oper,  md_wb_regdest,  md_wb_writereg,  md_wb_wbvalue}  = md;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag, input logic done, input logic we, input logic [4:0] addr,
                             input logic [31:0] data, input logic [1:0] unit, input logic [4:0] rd,
                             input logic stall, input logic ovf);
        chk({tag, ".done"},    {31'd0, wb_iss_done},        {31'd0, done});
        chk({tag, ".we"},      {31'd0, wb_rf_writeenable},  {31'd0, we});
        chk({tag, ".addr"},    {27'd0, wb_rf_writeaddr},    {27'd0, addr});
        chk({tag, ".data"},    wb_rf_writedata,             data);
        chk({tag, ".unit"},    {30'd0, wb_iss_doneunit},    {30'd0, unit});
        chk({tag, ".regdest"}, {27'd0, wb_iss_doneregdest}, {27'd0, rd});
        chk({tag, ".stall"},   {31'd0, wb_iss_stall},       {31'd0, stall});
        chk({tag, ".ovf"},     {31'd0, wb_overflow},        {31'd0, ovf});
    endtask

    initial begin
        // Expected outputs after the edge at which each row's inputs are applied
        vecs.push_back(mk(pu(5,1,32'h12345678), c_NONE, c_NONE,          0,0,5'd0, 32'h0,        2'd0,5'd0, 1,0));
        vecs.push_back(mk(c_NONE, c_NONE, c_NONE,                         1,1,5'd5, 32'h12345678, 2'd0,5'd5, 0,0));
        vecs.push_back(mk(c_NONE, c_NONE, c_NONE,                         0,0,5'd5, 32'h12345678, 2'd0,5'd5, 0,0));
        vecs.push_back(mk(pu(3,1,32'hA), pu(4,1,32'hB), pu(6,1,32'hC),    0,0,5'd5, 32'h12345678, 2'd0,5'd5, 1,0));
        vecs.push_back(mk(c_NONE, c_NONE, c_NONE,                         1,1,5'd4, 32'hB,        2'd1,5'd4, 1,0));
        vecs.push_back(mk(c_NONE, c_NONE, c_NONE,                         1,1,5'd6, 32'hC,        2'd2,5'd6, 1,0));
        vecs.push_back(mk(c_NONE, c_NONE, c_NONE,                         1,1,5'd3, 32'hA,        2'd0,5'd3, 0,0));
        vecs.push_back(mk(pu(0,1,32'hDEAD), c_NONE, c_NONE,               0,0,5'd3, 32'hA,        2'd0,5'd3, 1,0));
        vecs.push_back(mk(pu(7,0,32'hBEEF), c_NONE, c_NONE,               1,0,5'd0, 32'hDEAD,     2'd0,5'd0, 1,0));
        vecs.push_back(mk(c_NONE, c_NONE, c_NONE,                         1,0,5'd7, 32'hBEEF,     2'd0,5'd7, 0,0));
        vecs.push_back(mk(pu(8,1,32'hA1), pu(1,1,32'h100), c_NONE,        0,0,5'd7, 32'hBEEF,     2'd0,5'd7, 1,0));
        vecs.push_back(mk(pu(9,1,32'hA2), pu(1,1,32'h101), c_NONE,        1,1,5'd1, 32'h100,      2'd1,5'd1, 1,0));
        vecs.push_back(mk(pu(10,1,32'hA3), pu(1,1,32'h102), c_NONE,       1,1,5'd1, 32'h101,      2'd1,5'd1, 1,1));
        vecs.push_back(mk(c_NONE, c_NONE, c_NONE,                         1,1,5'd1, 32'h102,      2'd1,5'd1, 1,1));
        vecs.push_back(mk(c_NONE, c_NONE, c_NONE,                         1,1,5'd8, 32'hA1,       2'd0,5'd8, 1,1));
        vecs.push_back(mk(c_NONE, c_NONE, c_NONE,                         1,1,5'd9, 32'hA2,       2'd0,5'd9, 0,1));
        vecs.push_back(mk(c_NONE, c_NONE, c_NONE,                         0,0,5'd9, 32'hA2,       2'd0,5'd9, 0,1));
        vecs.push_back(mk(c_NONE, c_NONE, pu(11,1,32'hC0),                0,0,5'd9, 32'hA2,       2'd0,5'd9, 1,1));
        vecs.push_back(mk(c_NONE, c_NONE, pu(12,1,32'hC1),                1,1,5'd11,32'hC0,       2'd2,5'd11,1,1));
        vecs.push_back(mk(c_NONE, c_NONE, pu(13,1,32'hC2),                1,1,5'd12,32'hC1,       2'd2,5'd12,1,1));
        vecs.push_back(mk(c_NONE, c_NONE, pu(14,1,32'hC3),                1,1,5'd13,32'hC2,       2'd2,5'd13,1,1));
        vecs.push_back(mk(c_NONE, c_NONE, pu(15,1,32'hC4),                1,1,5'd14,32'hC3,       2'd2,5'd14,1,1));
        vecs.push_back(mk(c_NONE, c_NONE, pu(16,1,32'hC5),                1,1,5'd15,32'hC4,       2'd2,5'd15,1,1));
        vecs.push_back(mk(c_NONE, c_NONE, c_NONE,                         1,1,5'd16,32'hC5,       2'd2,5'd16,0,1));
        // oper=0 with other fields active must push nothing
        vecs.push_back(mk({1'b0,5'd3,1'b1,32'hFFFF}, {1'b0,5'd4,1'b1,32'h1}, c_NONE,
                                                                          0,0,5'd16,32'hC5,       2'd2,5'd16,0,1));
        vecs.push_back(mk(c_NONE, c_NONE, c_NONE,                         0,0,5'd16,32'hC5,       2'd2,5'd16,0,1));

        reset = 1'b0;
        drive(c_NONE, c_NONE, c_NONE);
        #1;
        check_all("reset", 0,0,5'd0,32'h0,2'd0,5'd0,0,0);
        step();
        step();
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].am, vecs[i].mem, vecs[i].md);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].e_done, vecs[i].e_we, vecs[i].e_addr,
                      vecs[i].e_data, vecs[i].e_unit, vecs[i].e_rd, vecs[i].e_stall, vecs[i].e_ovf);
        end

        // Two entries queued with overflow set, then asynchronous reset mid-cycle
        drive(pu(20,1,32'hE0), c_NONE, pu(21,1,32'hE1));
        step();
        check_all("preflush", 0,0,5'd16,32'hC5,2'd2,5'd16,1,1);
        drive(c_NONE, c_NONE, c_NONE);
        #1;
        reset = 1'b0;
        #1;
        check_all("asyncrst", 0,0,5'd0,32'h0,2'd0,5'd0,0,0);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_all($sformatf("postrst%0d", k), 0,0,5'd0,32'h0,2'd0,5'd0,0,0);
        end

        // Fresh operation after reset still works
        drive(c_NONE, pu(2,1,32'h55), c_NONE);
        step();
        drive(c_NONE, c_NONE, c_NONE);
        step();
        check_all("after", 1,1,5'd2,32'h55,2'd1,5'd2,0,0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
